// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write side: register count,
// the hard-wired zero register, default widths and the write-back entry record.
package cpu_pkg;

    localparam int REG_NUM        = 32;
    localparam int ZERO_REG       = 0;
    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;

    // One buffered long-op result. live=0 means the slot is empty or its
    // result was superseded by a younger ALU write to the same register.
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] rd;
        logic [DATA_W_DEFAULT-1:0] data;
        logic                      live;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's ALU, long-op and register-file signals.
// slave is the arbiter's view, master is the surrounding pipeline's view.
interface wb_arbiter_if #(
    parameter int DATA_W = cpu_pkg::DATA_W_DEFAULT,
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEFAULT
);

    logic                        alu_valid;
    logic [ADDR_W-1:0]           alu_rd;
    logic [DATA_W-1:0]           alu_data;
    logic                        alu_stall;
    logic                        mem_valid;
    logic                        mem_ready;
    logic [ADDR_W-1:0]           mem_rd;
    logic [DATA_W-1:0]           mem_data;
    logic                        RegWrite;
    logic [ADDR_W-1:0]           WriteReg;
    logic [DATA_W-1:0]           WriteData;
    logic [cpu_pkg::REG_NUM-1:0] pending;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_stall, mem_ready, RegWrite, WriteReg, WriteData, pending
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_stall, mem_ready, RegWrite, WriteReg, WriteData, pending
    );

endinterface

// File: rtl/wb_fifo.sv
// Small in-order buffer for long-latency results. Each slot can be killed by
// a destination-register compare, and the live slots form a pending mask.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  pushRd,
    input  logic [DATA_W-1:0]  pushData,
    input  logic               pop,
    input  logic               kill,
    input  logic [ADDR_W-1:0]  killRd,
    output wb_entry_t          head,
    output logic               full,
    output logic               empty,
    output logic [REG_NUM-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic             pushOk;
    logic             popOk;

    wb_entry_t          slots [DEPTH];
    logic [REG_NUM-1:0] slotMask [DEPTH];

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;
    assign head   = slots[rdPtr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_entry_t entry;

            // Slot update: a push claims a free slot (never the one being
            // popped), a pop frees the head, a kill retires older results.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry <= '0;
                end else if (pushOk && (wrPtr == PTR_W'(gi))) begin
                    entry <= '{rd: pushRd, data: pushData, live: 1'b1};
                end else if (popOk && (rdPtr == PTR_W'(gi))) begin
                    entry.live <= 1'b0;
                end else if (kill && entry.live && (entry.rd == killRd)) begin
                    entry.live <= 1'b0;
                end
            end

            assign slots[gi]    = entry;
            assign slotMask[gi] = entry.live ? (REG_NUM'(1) << entry.rd) : '0;
        end
    endgenerate

    // Pending mask: any live slot marks its destination register as busy.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | slotMask[i];
        end
    end

    // Pointers wrap modulo DEPTH; occupancy decides full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter. ALU results normally win; buffered
// long-op results drain when the ALU is idle or after waiting too long.
// The entry record fixes the data/index widths to the package defaults.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t          head;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [REG_NUM-1:0] fifoPending;
    logic               preempt;
    logic               aluAccept;
    logic               pop;
    logic               push;
    logic               kill;
    logic               writeEn;
    logic [ADDR_W-1:0]  winRd;
    logic [DATA_W-1:0]  winData;
    logic [AGE_W-1:0]   ageReg;
    logic [AGE_W-1:0]   ageNext;

    wb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pushRd   (bus.mem_rd),
        .pushData (bus.mem_data),
        .pop      (pop),
        .kill     (kill),
        .killRd   (bus.alu_rd),
        .head     (head),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .pending  (fifoPending)
    );

    assign bus.alu_stall = preempt;
    assign bus.mem_ready = !fifoFull;
    assign bus.pending   = fifoPending;

    // Winner selection: a starved head beats the ALU, the ALU beats an
    // ordinary head, and writes to the zero register are swallowed.
    always_comb begin
        preempt   = !fifoEmpty && (ageReg >= AGE_W'(STARVE_LIMIT));
        aluAccept = bus.alu_valid && !preempt;
        pop       = preempt || (!bus.alu_valid && !fifoEmpty);
        push      = bus.mem_valid && !fifoFull && (bus.mem_rd != ADDR_W'(ZERO_REG));
        kill      = aluAccept && (bus.alu_rd != ADDR_W'(ZERO_REG));
        winRd     = bus.alu_rd;
        winData   = bus.alu_data;
        writeEn   = kill;
        if (pop) begin
            winRd   = head.rd;
            winData = head.data;
            writeEn = head.live && (head.rd != ADDR_W'(ZERO_REG));
        end
        ageNext = ageReg;
        if (fifoEmpty || pop) begin
            ageNext = '0;
        end else if (ageReg < AGE_W'(STARVE_LIMIT)) begin
            ageNext = ageReg + 1'b1;
        end
    end

    // Head age register: how long the current head has been passed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ageReg <= '0;
        end else begin
            ageReg <= ageNext;
        end
    end

    // Registered write port: one-cycle RegWrite pulse per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RegWrite  <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
        end else begin
            bus.RegWrite <= writeEn;
            if (writeEn) begin
                bus.WriteReg  <= winRd;
                bus.WriteData <= winData;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: each step drives one cycle of stimulus,
// checks the combinational outputs, queues the expected register-file write
// and compares it against the registered outputs after the clock edge.
module tb_wb_arbiter;

    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_wr_t;

    exp_wr_t sb [$];

    wb_arbiter_if bus ();

    wb_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check stall/ready/pending before the edge, then
    // compare the registered write after the edge. Entered and left at negedge.
    task automatic step(input string tag,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic eStall, input logic eReady, input logic [31:0] ePend,
                        input logic eWe, input logic [4:0] eRd, input logic [31:0] eData);
        exp_wr_t e;
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mr;
        bus.mem_data  = md;
        #1;
        check({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(eStall));
        check({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'(eReady));
        check({tag, ".pending"}, bus.pending, ePend);
        sb.push_back('{we: eWe, rd: eRd, data: eData});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(e.we));
        if (e.we) begin
            check({tag, ".WriteReg"}, 32'(bus.WriteReg), 32'(e.rd));
            check({tag, ".WriteData"}, bus.WriteData, e.data);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [31:0] ePend,
                        input logic eWe, input logic [4:0] eRd, input logic [31:0] eData);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 1, ePend, eWe, eRd, eData);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
        repeat (2) @(negedge clk);
        check("rst.RegWrite", 32'(bus.RegWrite), 32'd0);
        check("rst.WriteReg", 32'(bus.WriteReg), 32'd0);
        check("rst.WriteData", bus.WriteData, 32'd0);
        check("rst.pending", bus.pending, 32'd0);
        check("rst.mem_ready", 32'(bus.mem_ready), 32'd1);
        check("rst.alu_stall", 32'(bus.alu_stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU only
        step("alu0", 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h0, 1, 3, 32'hDEADBEEF);
        idle("alu1", 32'h0, 0, 0, 0);

        // FIFO fill with a continuously busy ALU; head starves then preempts
        step("fill0", 1, 7, 32'h70, 1, 5, 32'h11, 0, 1, 32'h00, 1, 7, 32'h70);
        step("fill1", 1, 7, 32'h71, 1, 6, 32'h22, 0, 1, 32'h20, 1, 7, 32'h71);
        step("fill2", 1, 7, 32'h72, 0, 0, 0, 0, 0, 32'h60, 1, 7, 32'h72);
        step("fill3", 1, 7, 32'h73, 0, 0, 0, 0, 0, 32'h60, 1, 7, 32'h73);
        step("fill4", 1, 7, 32'h74, 0, 0, 0, 0, 0, 32'h60, 1, 7, 32'h74);
        step("fill5", 1, 7, 32'h75, 0, 0, 0, 1, 0, 32'h60, 1, 5, 32'h11);
        step("fill6", 1, 7, 32'h75, 0, 0, 0, 0, 1, 32'h40, 1, 7, 32'h75);
        step("fill7", 1, 7, 32'h76, 0, 0, 0, 0, 1, 32'h40, 1, 7, 32'h76);
        step("fill8", 1, 7, 32'h77, 0, 0, 0, 0, 1, 32'h40, 1, 7, 32'h77);
        step("fill9", 1, 7, 32'h78, 0, 0, 0, 0, 1, 32'h40, 1, 7, 32'h78);
        step("fill10", 1, 7, 32'h79, 0, 0, 0, 1, 1, 32'h40, 1, 6, 32'h22);
        step("fill11", 1, 7, 32'h79, 0, 0, 0, 0, 1, 32'h00, 1, 7, 32'h79);
        idle("fill12", 32'h0, 0, 0, 0);

        // WAW kill of an older queued result
        step("waw0", 0, 0, 0, 1, 9, 32'hAAAA, 0, 1, 32'h000, 0, 0, 0);
        step("waw1", 1, 9, 32'hBBBB, 0, 0, 0, 0, 1, 32'h200, 1, 9, 32'hBBBB);
        idle("waw2", 32'h0, 0, 0, 0);
        idle("waw3", 32'h0, 0, 0, 0);

        // Same-cycle push to the same register is younger and survives
        step("young0", 1, 9, 32'hCCCC, 1, 9, 32'hDDDD, 0, 1, 32'h000, 1, 9, 32'hCCCC);
        idle("young1", 32'h200, 1, 9, 32'hDDDD);
        idle("young2", 32'h0, 0, 0, 0);

        // Register 0 never writes and is never buffered
        step("zero0", 1, 0, 32'h1234, 1, 0, 32'h5678, 0, 1, 32'h0, 0, 0, 0);
        step("zero1", 1, 0, 32'h1235, 1, 0, 32'h5679, 0, 1, 32'h0, 0, 0, 0);
        step("zero2", 1, 0, 32'h1236, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
        idle("zero3", 32'h0, 0, 0, 0);

        // Simultaneous push and pop with one entry held
        step("pp0", 1, 11, 32'hB0, 1, 1, 32'h01, 0, 1, 32'h0, 1, 11, 32'hB0);
        step("pp1", 0, 0, 0, 1, 2, 32'h02, 0, 1, 32'h2, 1, 1, 32'h01);
        idle("pp2", 32'h4, 1, 2, 32'h02);
        idle("pp3", 32'h0, 0, 0, 0);

        // Reset in the middle of operation with two entries queued
        step("mr0", 1, 12, 32'hC0, 1, 13, 32'hD0, 0, 1, 32'h0000, 1, 12, 32'hC0);
        step("mr1", 1, 12, 32'hC1, 1, 14, 32'hE0, 0, 1, 32'h2000, 1, 12, 32'hC1);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        check("mr.pending_before", bus.pending, 32'h6000);
        check("mr.ready_before", 32'(bus.mem_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr.RegWrite", 32'(bus.RegWrite), 32'd0);
        check("mr.WriteReg", 32'(bus.WriteReg), 32'd0);
        check("mr.WriteData", bus.WriteData, 32'd0);
        check("mr.pending", bus.pending, 32'd0);
        check("mr.mem_ready", 32'(bus.mem_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr.first_edge", 32'(bus.RegWrite), 32'd0);
        @(negedge clk);
        idle("mr2", 32'h0, 0, 0, 0);
        idle("mr3", 32'h0, 0, 0, 0);
        idle("mr4", 32'h0, 0, 0, 0);

        check("sb.leftover", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
